// File: rtl/instr_fetch_unit.sv
// Instruction fetch: issues imem reads at the current PC, buffers in-order responses,
// hands them to decode, and drives the next PC, including branch redirects.
module instr_fetch_unit #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_in,
   output logic [ADDR_W-1:0] pc_next,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_addr,
   output logic              imem_req_valid,
   output logic [ADDR_W-1:0] imem_req_addr,
   input  logic              imem_req_ready,
   input  logic              imem_rsp_valid,
   input  logic [DATA_W-1:0] imem_rsp_data,
   output logic              inst_valid,
   output logic [DATA_W-1:0] inst_data,
   output logic [ADDR_W-1:0] inst_pc,
   input  logic              inst_ready
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   logic [ADDR_W-1:0] fifo_pc_q   [FIFO_DEPTH];
   logic [ADDR_W-1:0] fifo_pc_d   [FIFO_DEPTH];
   logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
   logic [DATA_W-1:0] fifo_data_d [FIFO_DEPTH];
   logic [ADDR_W-1:0] pend_pc_q   [FIFO_DEPTH];
   logic [ADDR_W-1:0] pend_pc_d   [FIFO_DEPTH];

   logic [PTR_W-1:0] fifo_wp_q, fifo_wp_d, fifo_rp_q, fifo_rp_d;
   logic [PTR_W-1:0] pend_wp_q, pend_wp_d, pend_rp_q, pend_rp_d;
   logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
   logic [CNT_W-1:0] outst_q, outst_d;
   logic [CNT_W-1:0] drop_q, drop_d;

   logic [CNT_W-1:0] live;
   logic [CNT_W:0]   fill;
   logic             req_fire, inst_fire, rsp_live;

   // Buffer fill counts every live in-flight response, so an accepted request always has a slot.
   always_comb begin
      live           = outst_q - drop_q;
      fill           = {1'b0, live} + {1'b0, fifo_cnt_q};
      imem_req_addr  = {pc_in[ADDR_W-1:2], 2'b00};
      imem_req_valid = !rst && !redirect_valid && (outst_q < CNT_W'(FIFO_DEPTH))
                       && (fill < (CNT_W+1)'(FIFO_DEPTH));
      req_fire       = imem_req_valid && imem_req_ready;
      inst_valid     = (fifo_cnt_q != '0) && !redirect_valid && !rst;
      inst_fire      = inst_valid && inst_ready;
      inst_data      = fifo_data_q[fifo_rp_q];
      inst_pc        = fifo_pc_q[fifo_rp_q];
      rsp_live       = imem_rsp_valid && (drop_q == '0);
      if (rst)
         pc_next = pc_in;
      else if (redirect_valid)
         pc_next = redirect_addr;
      else if (req_fire)
         pc_next = pc_in + ADDR_W'(4);
      else
         pc_next = pc_in;
   end

   always_comb begin
      fifo_pc_d   = fifo_pc_q;
      fifo_data_d = fifo_data_q;
      pend_pc_d   = pend_pc_q;
      fifo_wp_d   = fifo_wp_q;
      fifo_rp_d   = fifo_rp_q;
      pend_wp_d   = pend_wp_q;
      pend_rp_d   = pend_rp_q;
      fifo_cnt_d  = fifo_cnt_q;
      outst_d     = outst_q;
      drop_d      = drop_q;
      if (redirect_valid) begin
         fifo_wp_d  = '0;
         fifo_rp_d  = '0;
         pend_wp_d  = '0;
         pend_rp_d  = '0;
         fifo_cnt_d = '0;
         outst_d    = outst_q - CNT_W'(imem_rsp_valid);
         drop_d     = outst_q - CNT_W'(imem_rsp_valid);
      end else begin
         if (req_fire) begin
            pend_pc_d[pend_wp_q] = imem_req_addr;
            pend_wp_d            = pend_wp_q + PTR_W'(1);
         end
         if (rsp_live) begin
            fifo_pc_d[fifo_wp_q]   = pend_pc_q[pend_rp_q];
            fifo_data_d[fifo_wp_q] = imem_rsp_data;
            fifo_wp_d              = fifo_wp_q + PTR_W'(1);
            pend_rp_d              = pend_rp_q + PTR_W'(1);
         end
         // Dropped responses belong to entries already flushed, so they never touch the pending queue.
         if (imem_rsp_valid && !rsp_live)
            drop_d = drop_q - CNT_W'(1);
         if (inst_fire)
            fifo_rp_d = fifo_rp_q + PTR_W'(1);
         fifo_cnt_d = fifo_cnt_q + CNT_W'(rsp_live) - CNT_W'(inst_fire);
         outst_d    = outst_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
      end
   end

   always_ff @(posedge clk) begin
      fifo_pc_q   <= fifo_pc_d;
      fifo_data_q <= fifo_data_d;
      pend_pc_q   <= pend_pc_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fifo_wp_q  <= '0;
         fifo_rp_q  <= '0;
         pend_wp_q  <= '0;
         pend_rp_q  <= '0;
         fifo_cnt_q <= '0;
         outst_q    <= '0;
         drop_q     <= '0;
      end else begin
         fifo_wp_q  <= fifo_wp_d;
         fifo_rp_q  <= fifo_rp_d;
         pend_wp_q  <= pend_wp_d;
         pend_rp_q  <= pend_rp_d;
         fifo_cnt_q <= fifo_cnt_d;
         outst_q    <= outst_d;
         drop_q     <= drop_d;
      end
   end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: random memory/decode/redirect traffic checked
// against a program-order model of which fetched words must reach decode.
module tb_instr_fetch_unit;
   localparam int D = 2;
   localparam logic [31:0] KEY = 32'hA5A5_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_in = '0;
   logic [31:0] pc_next;
   logic        redirect_valid;
   logic [31:0] redirect_addr;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        inst_valid;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        inst_ready;

   int          n_chk = 0, n_fail = 0, n_deliv = 0, idle_cnt = 0;
   int          mem_rsp_pct = 100;
   logic [31:0] mq[$];
   logic [31:0] junk;
   exp_t        exq[$];
   logic [31:0] exp_fetch = '0;

   always #5 clk = ~clk;

   instr_fetch_unit #(.ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(D)) dut (
      .clk(clk), .rst(rst), .pc_in(pc_in), .pc_next(pc_next),
      .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
      .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
      .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data), .inst_valid(inst_valid), .inst_data(inst_data),
      .inst_pc(inst_pc), .inst_ready(inst_ready)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // PC register: loads pc_next every cycle.
   always @(posedge clk) pc_in <= pc_next;

   // In-order memory, response at least one cycle after accept, cleared by the shared reset.
   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         imem_rsp_valid <= 1'b0;
      end else begin
         if (imem_rsp_valid) junk = mq.pop_front();
         if (imem_req_valid && imem_req_ready) mq.push_back(imem_req_addr);
         if (mq.size() > 0 && $urandom_range(99) < mem_rsp_pct) begin
            imem_rsp_valid <= 1'b1;
            imem_rsp_data  <= mq[0] ^ KEY;
         end else begin
            imem_rsp_valid <= 1'b0;
         end
      end
   end

   // Monitor: every fetch accepted since the last redirect/reset must reach decode, in order.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
         chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
         chk("rst_pc_next", pc_next, pc_in);
         exq.delete();
         exp_fetch = pc_in;
         idle_cnt  = 0;
      end else if (redirect_valid) begin
         chk("redir_inst_valid", {31'b0, inst_valid}, 32'd0);
         chk("redir_req_valid", {31'b0, imem_req_valid}, 32'd0);
         chk("redir_pc_next", pc_next, redirect_addr);
         exq.delete();
         exp_fetch = redirect_addr;
         idle_cnt  = 0;
      end else begin
         if (inst_valid && inst_ready) begin
            idle_cnt = 0;
            if (exq.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL spurious_inst: got pc %h, none expected", inst_pc);
            end else begin
               e = exq.pop_front();
               chk("inst_pc", inst_pc, e.pc);
               chk("inst_data", inst_data, e.data);
               n_deliv++;
            end
         end else if (exq.size() > 0 && inst_ready) begin
            idle_cnt++;
            if (idle_cnt > 200) begin
               n_chk++; n_fail++;
               $display("FAIL delivery_timeout: %0d entries stuck, want 0", exq.size());
               idle_cnt = 0;
            end
         end
         if (imem_req_valid) begin
            chk("req_addr", imem_req_addr, {exp_fetch[31:2], 2'b00});
            chk("pc_next_issue", pc_next, imem_req_ready ? pc_in + 32'd4 : pc_in);
         end else begin
            chk("pc_next_hold", pc_next, pc_in);
         end
         if (imem_req_valid && imem_req_ready) begin
            exq.push_back('{pc: {exp_fetch[31:2], 2'b00}, data: {exp_fetch[31:2], 2'b00} ^ KEY});
            exp_fetch = exp_fetch + 32'd4;
         end
         chk("buffer_capacity", {31'b0, exq.size() <= D}, 32'd1);
         chk("outstanding_bound", {31'b0, mq.size() <= D}, 32'd1);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic redirect_to(input logic [31:0] a);
      redirect_valid = 1'b1;
      redirect_addr  = a;
      cyc(1);
      redirect_valid = 1'b0;
   endtask

   initial begin
      int base;
      rst = 1'b1; redirect_valid = 1'b0; redirect_addr = '0;
      imem_req_ready = 1'b1; inst_ready = 1'b1;
      // Streaming from reset at pc 0.
      cyc(2);
      rst = 1'b0;
      cyc(40);
      chk("stream_progress", {31'b0, n_deliv >= 15}, 32'd1);

      // Decode backpressure: two fetches then hold at 0x8.
      inst_ready = 1'b0;
      redirect_to(32'h0);
      cyc(8);
      chk("bp_buffered", exq.size(), 32'd2);
      chk("bp_req_valid", {31'b0, imem_req_valid}, 32'd0);
      chk("bp_pc_next", pc_next, 32'h8);
      base = n_deliv;
      inst_ready = 1'b1;
      cyc(20);
      chk("bp_resume", {31'b0, n_deliv >= base + 4}, 32'd1);

      // Memory stall at 0x20.
      imem_req_ready = 1'b0;
      redirect_to(32'h20);
      cyc(3);
      chk("stall_pc", pc_in, 32'h20);
      chk("stall_addr", imem_req_addr, 32'h20);
      imem_req_ready = 1'b1;
      cyc(10);

      // Redirect with two fetches in flight; late responses must be dropped.
      imem_req_ready = 1'b0;
      cyc(6);
      mem_rsp_pct = 0;
      imem_req_ready = 1'b1;
      redirect_to(32'h0);
      cyc(4);
      chk("two_in_flight", mq.size(), 32'd2);
      redirect_to(32'h102);
      mem_rsp_pct = 100;
      base = n_deliv;
      cyc(15);
      chk("post_redirect_progress", {31'b0, n_deliv > base}, 32'd1);

      // Reset with a full buffer.
      inst_ready = 1'b0;
      cyc(8);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      inst_ready = 1'b1;
      cyc(10);

      // Random traffic with redirects (including wraparound targets) and occasional resets.
      mem_rsp_pct = 60;
      for (int i = 0; i < 3000; i++) begin
         rst            = ($urandom_range(199) == 0);
         redirect_valid = !rst && ($urandom_range(99) < 6);
         redirect_addr  = ($urandom_range(9) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(15))
                                                   : ($urandom & 32'h0000_FFFF);
         imem_req_ready = ($urandom_range(99) < 70);
         inst_ready     = ($urandom_range(99) < 75);
         cyc(1);
      end

      // Drain: fetch must keep flowing.
      rst = 1'b0; redirect_valid = 1'b0; imem_req_ready = 1'b1; inst_ready = 1'b1;
      mem_rsp_pct = 100;
      base = n_deliv;
      cyc(40);
      chk("drain_progress", {31'b0, n_deliv >= base + 15}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
